// File: rtl/mms_pkg.sv
// mms_pkg: shared fetch-state type and word/PC constants for the memory management system
package mms_pkg;
   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] DEF_RESET_PC = 16'h0000;
   localparam logic [WORD_W-1:0] DEF_PC_STEP = 16'd2;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_wait_ctr.sv
// fetch_wait_ctr: loadable down-counter timing the memory read latency
module fetch_wait_ctr #(
   parameter int MEM_LAT = 1,
   parameter int W = $clog2(MEM_LAT + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (dec && cnt != '0) cnt <= cnt - W'(1);
   end
   assign zero = cnt == '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner that fetches one word at a time and hands it to decode over valid/ready
module instr_fetch_unit
   import mms_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [WORD_W-1:0] PC_STEP = DEF_PC_STEP,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic [WORD_W-1:0] mem_a1,
   output logic              mem_r1,
   output logic              mem_w1,
   input  logic [WORD_W-1:0] mem_ir,
   output logic [WORD_W-1:0] ir,
   output logic [WORD_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready
);
   localparam int CW = $clog2(MEM_LAT + 1);
   fetch_state_t state, state_n;
   logic [WORD_W-1:0] pc, pc_n;
   logic cap, hs, ctr_zero;
   assign hs = ir_valid && ir_ready;
   assign mem_a1 = pc;
   assign mem_r1 = state == ISSUE;
   assign mem_w1 = 1'b0;
   fetch_wait_ctr #(.MEM_LAT(MEM_LAT), .W(CW)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (state == ISSUE),
      .dec      (state == WAIT),
      .load_val (CW'(MEM_LAT - 1)),
      .zero     (ctr_zero)
   );
   always_comb begin
      state_n = state;
      pc_n = pc;
      cap = 1'b0;
      case (state)
         IDLE: state_n = start ? ISSUE : IDLE;
         ISSUE: state_n = WAIT;
         WAIT: begin
            cap = ctr_zero;
            state_n = ctr_zero ? HOLD : WAIT;
         end
         HOLD: begin
            state_n = hs ? ISSUE : HOLD;
            pc_n = hs ? pc + PC_STEP : pc;
         end
         default: state_n = IDLE;
      endcase
      // a redirect kills any in-flight or held word and refetches from the new target
      if (redirect) begin
         pc_n = redirect_pc;
         cap = 1'b0;
         state_n = (state == IDLE) ? IDLE : ISSUE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc <= RESET_PC;
         ir <= '0;
         ir_pc <= '0;
         ir_valid <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         ir_valid <= cap || (ir_valid && !hs && !redirect);
         if (cap) begin
            ir <= mem_ir;
            ir_pc <= pc;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench with a latency-exact memory model
module tb_instr_fetch_unit;
   localparam logic [15:0] RST_PC = 16'hFFFC;
   localparam int LAT = 3;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, redirect = 1'b0, ir_ready = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic [15:0] mem_a1, mem_ir, ir, ir_pc;
   logic mem_r1, mem_w1, ir_valid;
   int tests = 0, fails = 0;
   instr_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(16'd2), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_a1(mem_a1), .mem_r1(mem_r1), .mem_w1(mem_w1), .mem_ir(mem_ir),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready)
   );
   always #5 clk = ~clk;
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C69;
   endfunction
   // memory returns the word only in the exact cycle LAT after the strobe, junk otherwise
   logic [16:0] pipe [LAT];
   initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
   always @(posedge clk) begin
      pipe[0] <= {mem_r1, mem_a1};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_ir = pipe[LAT-1][16] ? mem_word(pipe[LAT-1][15:0]) : 16'hDEAD;
   task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   task automatic step(input logic rs, input logic st, input logic rd, input logic [15:0] rp, input logic rdy);
      reset = rs; start = st; redirect = rd; redirect_pc = rp; ir_ready = rdy;
      @(posedge clk);
      #1;
   endtask
   // reference model: tracks the architectural PC and the next word decode must see
   logic [15:0] exp_q [$];
   logic [15:0] mpc = RST_PC, p_ir, p_pc, e;
   logic running = 1'b0, inited = 1'b0, hold_prev = 1'b0, pv = 1'b0;
   int cyc = 0, last_iss = 0;
   initial forever begin
      @(negedge clk);
      cyc++;
      if (inited) begin
         chk("mem_a1", {32'd0, mem_a1}, {32'd0, mpc});
         chk("mem_w1", {47'd0, mem_w1}, 48'd0);
         if (!running) chk("idle_quiet", {46'd0, mem_r1, ir_valid}, 48'd0);
         if (mem_r1) chk("no_pipelining", {47'd0, ir_valid}, 48'd0);
         if (hold_prev) chk("hold_stable", {15'd0, ir_valid, ir, ir_pc}, {15'd0, 1'b1, p_ir, p_pc});
         if (ir_valid && !pv) chk("latency", 48'(cyc - last_iss), 48'(LAT + 1));
         if (ir_valid && ir_ready && !reset) begin
            if (exp_q.size() == 0) chk("unexpected_xfer", {32'd0, ir_pc}, 48'hFFFF_FFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("ir_pc", {32'd0, ir_pc}, {32'd0, e});
               chk("ir", {32'd0, ir}, {32'd0, mem_word(e)});
            end
         end
      end
      if (reset) begin
         exp_q.delete();
         mpc = RST_PC;
         running = 1'b0;
         inited = 1'b1;
      end else if (inited) begin
         if (redirect) begin
            mpc = redirect_pc;
            exp_q.delete();
            if (running) exp_q.push_back(mpc);
         end else if (!running && start) begin
            running = 1'b1;
            exp_q.push_back(mpc);
         end else if (ir_valid && ir_ready) begin
            mpc = mpc + 16'd2;
            exp_q.push_back(mpc);
         end
      end
      hold_prev = !reset && !redirect && ir_valid && !ir_ready;
      p_ir = ir;
      p_pc = ir_pc;
      pv = ir_valid;
      if (mem_r1) last_iss = cyc;
   end
   initial begin
      int k;
      repeat (3) step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rst_valid", {47'd0, ir_valid}, 48'd0);
      chk("rst_r1", {47'd0, mem_r1}, 48'd0);
      chk("rst_a1", {32'd0, mem_a1}, {32'd0, RST_PC});
      chk("rst_ir", {32'd0, ir}, 48'd0);
      chk("rst_ir_pc", {32'd0, ir_pc}, 48'd0);
      step(0, 1, 0, 0, 0);
      for (k = 0; k < 20 && !ir_valid; k++) step(0, 0, 0, 0, 0);
      chk("first_latency", 48'(k), 48'(LAT + 1));
      chk("first_ir_pc", {32'd0, ir_pc}, {32'd0, RST_PC});
      chk("first_ir", {32'd0, ir}, {32'd0, mem_word(RST_PC)});
      repeat (5) step(0, 0, 0, 0, 0);
      chk("bp_r1", {47'd0, mem_r1}, 48'd0);
      chk("bp_a1", {32'd0, mem_a1}, {32'd0, RST_PC});
      repeat (20) step(0, 0, 0, 0, 1);
      for (k = 0; k < 20 && !mem_r1; k++) step(0, 0, 0, 0, 1);
      chk("wait_issue", {47'd0, mem_r1}, 48'd1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 16'h0040, 1);
      for (k = 0; k < 20 && !ir_valid; k++) step(0, 0, 0, 0, 0);
      chk("redir_wait_pc", {32'd0, ir_pc}, 48'h0040);
      chk("redir_wait_ir", {32'd0, ir}, {32'd0, mem_word(16'h0040)});
      step(0, 0, 1, 16'h0100, 1);
      chk("redir_hs_a1", {32'd0, mem_a1}, 48'h0100);
      chk("redir_hs_valid", {47'd0, ir_valid}, 48'd0);
      repeat (10) step(0, 0, 0, 0, 1);
      for (k = 0; k < 20 && !mem_r1; k++) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      chk("rstw_valid", {47'd0, ir_valid}, 48'd0);
      chk("rstw_r1", {47'd0, mem_r1}, 48'd0);
      chk("rstw_a1", {32'd0, mem_a1}, {32'd0, RST_PC});
      repeat (6) step(0, 0, 0, 0, 1);
      chk("rstw_no_fetch", {47'd0, mem_r1}, 48'd0);
      step(0, 0, 1, 16'h0033, 1);
      step(0, 1, 0, 0, 1);
      repeat (3000) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 7) == 0 ? 16'hFFFE : 16'($urandom), $urandom_range(0, 9) < 6);
      end
      repeat (20) step(0, 0, 0, 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream instruction-fetch stage for the memory management system; owns the program counter.
- Drives the instruction read port (address, read strobe, write strobe tied low) and captures the returned instruction word.
- Presents the captured word and its PC to decode through a valid/ready handshake.
- Supports a redirect input for branches and jumps that discards any in-flight fetch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 2, PC increment per sequential fetch; the memory is byte-addressed with 16-bit words.
MEM_LAT, 1, cycles from the read strobe to valid read data on mem_ir; must be at least 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  leave IDLE and begin fetching at the current PC.
redirect  in  1  branch/jump taken; one-cycle pulse.
redirect_pc  in  16  new fetch address, valid while redirect=1.
mem_a1  out  16  instruction read address to memory port 1.
mem_r1  out  1  instruction read strobe.
mem_w1  out  1  write strobe for port 1; constant 0.
mem_ir  in  16  read data from memory port 1.
ir  out  16  fetched instruction word.
ir_pc  out  16  address ir was fetched from.
ir_valid  out  1  ir/ir_pc valid.
ir_ready  in  1  decode accepts ir this cycle.

Behaviour:
- Reset values: pc=RESET_PC; state=IDLE; ir=0; ir_pc=0; ir_valid=0; mem_r1=0; mem_a1=RESET_PC; mem_w1=0; wait counter=0.
- mem_a1 always equals pc (registered). mem_r1 is decoded from state and is high only in ISSUE.
- State IDLE:
  - If start=1 and redirect=0, go to ISSUE next cycle.
  - If redirect=1, set pc<=redirect_pc and stay in IDLE.
- State ISSUE (one cycle):
  - Assert mem_r1=1.
  - Load wait counter with MEM_LAT-1.
  - Go to WAIT.
- State WAIT:
  - When the counter reaches 0 (MEM_LAT cycles after ISSUE), sample mem_ir on that edge.
  - At the same edge: ir<=mem_ir; ir_pc<=pc; ir_valid<=1; go to HOLD.
  - Otherwise decrement the counter.
  - With MEM_LAT=1, the sample occurs in the first WAIT cycle.
- State HOLD:
  - ir, ir_pc and ir_valid are held stable until the handshake.
  - On ir_valid&&ir_ready: ir_valid<=0; pc<=pc+PC_STEP; go to ISSUE.
- Latency and throughput:
  - ir_valid rises MEM_LAT+1 cycles after the ISSUE cycle.
  - With ir_ready held high, there is one instruction per MEM_LAT+2 cycles. No fetch pipelining.
- PC arithmetic: 16-bit unsigned; pc+PC_STEP wraps modulo 2^16 (16'hFFFE+2 gives 16'h0000).
- Redirect has priority over everything except reset:
  - In ISSUE or WAIT: abandon the fetch; the returning mem_ir is never sampled; pc<=redirect_pc; next state ISSUE.
  - In HOLD without handshake: ir_valid<=0 (the word is dropped); pc<=redirect_pc; next state ISSUE.
  - In HOLD with a simultaneous handshake: the transfer counts as accepted; the next pc is redirect_pc, not pc+PC_STEP.
  - No stale word may ever reach decode after a redirect.
- Unasserted redirect_pc is don't-care. Odd redirect_pc values are passed through unmodified.
- Reset mid-operation: all state returns to its reset values on the next edge. Any in-flight memory data is ignored.
- start is ignored outside IDLE.
- ir_ready is ignored while ir_valid=0.

Decomposition:
- Shared package (mms_pkg):
  - fetch-state enumeration IDLE/ISSUE/WAIT/HOLD, 2-bit encoding;
  - WORD_W=16 constant;
  - default RESET_PC and PC_STEP constants.
- One sub-module: fetch_wait_ctr, a loadable down-counter of width clog2(MEM_LAT+1) with load, decrement and zero flag.
- PC register and FSM stay in the top module.

Test Plan:
- Reset, then start with MEM_LAT=1; memory holds 16'h1234@0, 16'hABCD@2; ir_ready=1.
  → ir_valid at cycle 3 after start; ir=16'h1234, ir_pc=0; next ir=16'hABCD, ir_pc=2; 3-cycle cadence.
- Backpressure: ir_ready=0 for 5 cycles while ir_valid=1.
  → ir and ir_pc stable; mem_r1 stays 0; pc advances only after ready rises.
- Redirect during WAIT with redirect_pc=16'h0040 (mem@0x40=16'h5555, MEM_LAT=3).
  → the old data is never presented; the first ir after redirect is 16'h5555 with ir_pc=16'h0040.
- Redirect coinciding with the handshake in HOLD (redirect_pc=16'h0100).
  → the current word is accepted once; the next mem_a1 is 16'h0100, not pc+2.
- Wrap-around: RESET_PC=16'hFFFE.
  → ir_pc sequence is 16'hFFFE then 16'h0000.
- Reset asserted in WAIT.
  → next cycle ir_valid=0, mem_r1=0, mem_a1=RESET_PC, state IDLE; no fetch until start.
